// File: rtl/pearson_hash_stream.sv
// Streaming multi-lane Pearson hash: one message byte per cycle over valid/ready,
// LANES parallel 8-bit lanes sharing one runtime-loadable 256x8 permutation table.
module pearson_hash_stream #(
    parameter int LANES     = 2,
    parameter int LEN_W     = 16,
    parameter int PERM_MULT = 167,
    parameter int PERM_ADD  = 13
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 hash_valid,
    input  logic                 hash_ready,
    output logic [8*LANES-1:0]   hash,
    output logic [LEN_W-1:0]     msg_len,
    input  logic                 tbl_we,
    input  logic [7:0]           tbl_addr,
    input  logic [7:0]           tbl_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tbl_q    [256];
    logic [7:0]       tbl_d    [256];
    logic [7:0]       lane_q   [LANES];
    logic [7:0]       lane_d   [LANES];
    logic [7:0]       lane_idx [LANES];
    logic [LEN_W-1:0] len_q, len_d;
    logic             accept;
    logic             tbl_wr;

    assign accept = in_valid && in_ready;
    assign tbl_wr = tbl_we && (state_q == S_IDLE);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every comb output gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = in_last ? S_DONE : S_RUN;
            S_RUN:   if (accept && in_last) state_d = S_DONE;
            S_DONE:  if (hash_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        in_ready   = 1'b0;
        hash_valid = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                in_ready = !tbl_we;
                busy     = 1'b0;
            end
            S_RUN:   in_ready   = 1'b1;
            S_DONE:  hash_valid = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    // Lanes stay live after DONE, so the result is masked rather than cleared.
    always_comb begin
        hash = '0;
        if (state_q == S_DONE) begin
            for (int k = 0; k < LANES; k++) begin
                hash[8*k +: 8] = lane_q[k];
            end
        end
    end

    assign msg_len = len_q;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = (state_q == S_IDLE) ? (in_data + 8'(k)) : (lane_q[k] ^ in_data);
            lane_d[k]   = accept ? tbl_q[lane_idx[k]] : lane_q[k];
        end
    end

    always_comb begin
        len_d = len_q;
        if (accept) begin
            if (state_q == S_IDLE) begin
                len_d = LEN_W'(1);
            end else if (len_q != {LEN_W{1'b1}}) begin
                len_d = len_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (tbl_wr) begin
            tbl_d[tbl_addr] = tbl_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= 8'h00;
            end
            // NOTE: the table is a register array, not RAM, because it must reset to the default permutation.
            for (int i = 0; i < 256; i++) begin
                tbl_q[i] <= 8'((i * PERM_MULT + PERM_ADD) % 256);
            end
        end else begin
            len_q  <= len_d;
            lane_q <= lane_d;
            tbl_q  <= tbl_d;
        end
    end

endmodule

// File: tb/tb_pearson_hash_stream.sv
// Bench for pearson_hash_stream: directed vectors with literal expectations plus a
// whole-message reference model compared against the outputs on every cycle.
module tb_pearson_hash_stream;

    localparam int LANES = 2;
    localparam int LEN_W = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              hash_valid;
    logic              hash_ready = 1'b0;
    logic [15:0]       hash;
    logic [LEN_W-1:0]  msg_len;
    logic              tbl_we = 1'b0;
    logic [7:0]        tbl_addr = 8'h00;
    logic [7:0]        tbl_data = 8'h00;
    logic              busy;

    pearson_hash_stream #(.LANES(LANES), .LEN_W(LEN_W), .PERM_MULT(167), .PERM_ADD(13)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash       (hash),
        .msg_len    (msg_len),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    logic [7:0]  m_tbl [256];
    logic [7:0]  m_msg [$];
    int          m_len = 0;
    logic [15:0] m_hash = 16'h0;

    // Hash of the whole buffered message under the current table.
    function automatic logic [15:0] ref_hash();
        logic [15:0] r = 16'h0;
        for (int k = 0; k < LANES; k++) begin
            logic [7:0] h = m_tbl[8'(int'(m_msg[0]) + k)];
            for (int i = 1; i < m_msg.size(); i++) h = m_tbl[h ^ m_msg[i]];
            r[8*k +: 8] = h;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_len  = 0;
            m_msg.delete();
            for (int i = 0; i < 256; i++) m_tbl[i] = 8'((i * 167 + 13) % 256);
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (tbl_we) begin
                        m_tbl[tbl_addr] = tbl_data;
                    end else if (in_valid) begin
                        m_msg.delete();
                        m_msg.push_back(in_data);
                        m_len = 1;
                        if (in_last) begin
                            m_hash = ref_hash();
                            m_mode = M_DONE;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (in_valid) begin
                        m_msg.push_back(in_data);
                        if (m_len < (1 << LEN_W) - 1) m_len++;
                        if (in_last) begin
                            m_hash = ref_hash();
                            m_mode = M_DONE;
                        end
                    end
                end
                default: if (hash_ready) m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready",   in_ready,   ((m_mode == M_IDLE) && !tbl_we) || (m_mode == M_RUN));
            check("hash_valid", hash_valid, m_mode == M_DONE);
            check("busy",       busy,       m_mode != M_IDLE);
            check("msg_len",    msg_len,    m_len);
            check("hash",       hash,       (m_mode == M_DONE) ? m_hash : 16'h0);
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic send_byte(input logic [7:0] d, input logic last);
        int   cnt = 0;
        logic ok  = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end while (!ok && cnt < 20);
        if (!ok) check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic wait_hash(input int hold, output logic [15:0] h, output logic [LEN_W-1:0] len);
        int cnt = 0;
        hash_ready = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!hash_valid && cnt < 50);
        check("hash_valid_seen", hash_valid, 1'b1);
        h   = hash;
        len = msg_len;
        repeat (hold) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        hash_ready = 1'b1;
        @(posedge clk);
        #1;
        hash_ready = 1'b0;
        @(negedge clk);
        check("post_hs_hash",     hash,     16'h0);
        check("post_hs_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] msg8 [8] = '{8'd47, 8'd17, 8'd48, 8'd12, 8'd26, 8'd28, 8'd40, 8'd21};

    initial begin
        logic [15:0]      h;
        logic [LEN_W-1:0] len;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Reset values and the single-byte default-table vector.
        @(negedge clk);
        check("rst_in_ready",   in_ready,   1'b1);
        check("rst_hash_valid", hash_valid, 1'b0);
        check("rst_hash",       hash,       16'h0);
        check("rst_msg_len",    msg_len,    0);
        check("rst_busy",       busy,       1'b0);
        @(posedge clk);
        #1;
        send_byte(8'h00, 1'b1);
        check("t1_valid_next", hash_valid, 1'b1);
        wait_hash(0, h, len);
        check("t1_hash", h, 16'hB40D);
        check("t1_len",  len, 1);

        // Identity table, 8-byte message with 5 cycles of backpressure.
        for (int i = 0; i < 256; i++) begin
            tbl_we   = 1'b1;
            tbl_addr = 8'(i);
            tbl_data = 8'(i);
            @(posedge clk);
            #1;
        end
        tbl_we = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(msg8[i], i == 7);
        check("t2_valid_next", hash_valid, 1'b1);
        wait_hash(5, h, len);
        check("t2_hash", h, 16'h2639);
        check("t2_len",  len, 8);

        // Table write held during RUN (with a stall) must be ignored.
        send_byte(8'h01, 1'b0);
        tbl_we   = 1'b1;
        tbl_addr = 8'h00;
        tbl_data = 8'hAA;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_byte(8'h02, 1'b0);
        tbl_we = 1'b0;
        send_byte(8'h03, 1'b1);
        wait_hash(1, h, len);
        check("t3_hash", h, 16'h0300);
        check("t3_len",  len, 3);

        // Same write in IDLE blocks input and lands in the table.
        tbl_we   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        @(negedge clk);
        check("t3_we_blocks", in_ready, 1'b0);
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        send_byte(8'h00, 1'b1);
        wait_hash(0, h, len);
        check("t3_written_hash", h, 16'h01AA);

        // Reset pulse during byte 4 of an 8-byte message.
        for (int i = 0; i < 3; i++) send_byte(msg8[i], 1'b0);
        in_valid = 1'b1;
        in_data  = msg8[3];
        in_last  = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        check("t4_busy",       busy,       1'b0);
        check("t4_hash_valid", hash_valid, 1'b0);
        check("t4_msg_len",    msg_len,    0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        send_byte(8'h00, 1'b1);
        wait_hash(0, h, len);
        check("t4_hash", h, 16'hB40D);

        // 300-byte message with random gaps; msg_len saturates at 255.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(8'($urandom), i == 299);
        end
        wait_hash(2, h, len);
        check("t5_hash", h, m_hash);
        check("t5_len",  len, 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pearson_hash_stream.md
# pearson_hash_stream

Parametrised streaming Pearson hash engine, the successor to the fixed 8-byte, single-lane Pearson block. It accepts messages of arbitrary length, one byte per cycle, over a valid/ready interface. It produces a hash of 8*LANES bits, using one Pearson lane per output byte, all lanes sharing one 256x8 permutation table. The table is loadable at runtime and resets to a parametrised default permutation.

## Interface
- LANES, 2, number of 8-bit hash lanes; hash width = 8*LANES (1..8)
- LEN_W, 16, width of message byte counter
- PERM_MULT, 167, default table multiplier; must be odd
- PERM_ADD, 13, default table offset
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  message byte valid
- in_ready  out  1  engine accepts byte this cycle
- in_data  in  8  message byte
- in_last  in  1  byte is final byte of message
- hash_valid  out  1  hash result valid
- hash_ready  in  1  downstream accepts hash
- hash  out  8*LANES  result; lane k in bits [8k+7:8k]; zero when hash_valid=0
- msg_len  out  LEN_W  bytes in current/last message, saturating
- tbl_we  in  1  table write strobe
- tbl_addr  in  8  table write address
- tbl_data  in  8  table write data
- busy  out  1  state != IDLE

## Operation
- Table T[0..255]: on reset T[i] = (i*PERM_MULT + PERM_ADD) mod 256. Software must load a permutation; no check is made.
- Table writes are accepted only in IDLE. In IDLE, tbl_we has priority over input, so in_ready=0 while tbl_we=1. tbl_we in RUN or DONE is ignored.
- Lane k state h_k, updated on each accepted byte m_i:
  - First byte (i=0): h_k = T[(m_0 + k) mod 256].
  - Subsequent bytes: h_k = T[h_k XOR m_i].
  - All lanes update in the same cycle (LANES combinational read ports).
- States:
  - IDLE: in_ready = !tbl_we. On an accepted byte: compute first-byte lanes and set msg_len=1. If in_last, go to DONE; else go to RUN.
  - RUN: in_ready=1. On an accepted byte: update lanes and increment msg_len (saturating at 2^LEN_W-1). If in_last, go to DONE.
  - DONE: in_ready=0, hash_valid=1, hash=lanes. On hash_ready=1, go to IDLE.
- Lane registers are not cleared on the return to IDLE. hash is masked to zero outside DONE.
- msg_len holds its value through IDLE until the first byte of the next message, which sets it to 1.
- in_valid=0 in RUN stalls the engine indefinitely with no state change.

## Timing
- Reset values:
  - state=IDLE, in_ready=1 (given tbl_we=0), hash_valid=0, hash=0, msg_len=0, busy=0.
  - Lanes are 0 and the table holds the default permutation.
- Throughput is one byte per cycle with no bubbles between bytes of a message.
- hash_valid rises on the first clock edge after the in_last byte is accepted.
- The earliest next-message byte is accepted one cycle after the hash handshake (DONE→IDLE costs one cycle).
- Under backpressure (hash_ready=0), hash and msg_len are held stable.
- A single-byte message goes IDLE→DONE directly.
- A table write takes effect for any byte accepted on a later cycle.
- Reset asserted mid-message or in DONE: all outputs return to reset values immediately. The table reverts to the default, and any partial message is discarded.
- in_data and in_last are ignored when in_valid=0.

## Test plan
- After reset, with LANES=2 and the default table, send the single byte 0x00 with in_last=1 → next cycle hash_valid=1, hash=0xB40D, msg_len=1.
- Load the identity table (T[i]=i) in IDLE, then send 47,17,48,12,26,28,40,21 with last on byte 8 → hash=0x2639, msg_len=8, hash_valid exactly one cycle after the last byte.
- Backpressure: during the previous test, hold hash_ready=0 for 5 cycles → hash stays 0x2639 and in_ready stays 0. After the handshake, hash=0 and in_ready=1 one cycle later.
- Hold tbl_we=1 (addr 0x00, data 0xAA) in RUN, then finish the message → the table is unchanged and the hash equals the no-write result. The same write with in_valid=1 in IDLE → in_ready=0, and T[0x00]=0xAA is verified by a later single-byte 0x00 message giving lane0=0xAA.
- Pulse reset_n low during byte 4 of an 8-byte message → busy=0, hash_valid=0, msg_len=0 immediately. A following single-byte 0x00 message yields the default 0xB40D.
- Stream in_valid with random gaps over a 300-byte message (LEN_W=8 build) → the hash matches the reference model and msg_len saturates at 255.
